// File: rtl/sort.sv
// Odd-even transposition sorter: loads NUM entries, runs NUM passes (one per cycle), holds result.
// Define SORT_DESCEND_EN to sort in descending order; ascending otherwise.
module sort #(
    parameter int unsigned NUM   = 13,
    parameter int unsigned WIDTH = 10
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 sort_begin,
    input  logic [NUM*WIDTH-1:0] FREQUENT_IN,
    output logic                 sort_over,
    output logic [NUM*WIDTH-1:0] FREQUENT_OUT
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PASS = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int unsigned     CntW     = $clog2(NUM + 1);
    localparam logic [CntW-1:0] LastPass = CntW'(NUM - 1);

    logic [1:0]                      state_q, state_d;
    logic [CntW-1:0]                 pass_cnt_q, pass_cnt_d;
    logic [NUM-1:0][WIDTH-1:0]       arr_q, arr_d;
    logic [NUM-1:0][WIDTH-1:0]       pass_res;
    logic [NUM*WIDTH-1:0]            out_q, out_d;
    logic                            sort_over_q, sort_over_d;

    // True when a (lower index, higher index) pair must be swapped; equal values never swap.
    function automatic logic out_of_order(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
`ifdef SORT_DESCEND_EN
        return lo < hi;
`else
        return lo > hi;
`endif
    endfunction

    // Pairs within one pass are disjoint, so every compare reads the registered array.
    always_comb begin
        pass_res = arr_q;
        for (int i = 0; i < int'(NUM) - 1; i++) begin
            if (i[0] == pass_cnt_q[0]) begin
                if (out_of_order(arr_q[i], arr_q[i+1])) begin
                    pass_res[i]   = arr_q[i+1];
                    pass_res[i+1] = arr_q[i];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_cnt_d  = pass_cnt_q;
        arr_d       = arr_q;
        out_d       = out_q;
        sort_over_d = sort_over_q;
        case (state_q)
            IDLE: begin
                if (sort_begin) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                arr_d      = FREQUENT_IN;
                pass_cnt_d = '0;
                state_d    = PASS;
            end
            PASS: begin
                arr_d      = pass_res;
                pass_cnt_d = pass_cnt_q + 1'b1;
                if (pass_cnt_q == LastPass) begin
                    state_d     = DONE;
                    out_d       = pass_res;
                    sort_over_d = 1'b1;
                end
            end
            DONE: begin
                if (!sort_begin) begin
                    state_d     = IDLE;
                    sort_over_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                sort_over_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q     <= IDLE;
            pass_cnt_q  <= '0;
            arr_q       <= '0;
            out_q       <= '0;
            sort_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_cnt_q  <= pass_cnt_d;
            arr_q       <= arr_d;
            out_q       <= out_d;
            sort_over_q <= sort_over_d;
        end
    end

    assign sort_over    = sort_over_q;
    assign FREQUENT_OUT = out_q;

endmodule

// File: tb/tb_sort.sv
// Directed self-checking bench for sort: latency, ordering, hold/release, abort by reset.
module tb_sort;

    localparam int NUM   = 13;
    localparam int WIDTH = 10;
    localparam int VW    = NUM * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          sort_begin;
    logic [VW-1:0] freq_in;
    logic          sort_over;
    logic [VW-1:0] freq_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sort #(
        .NUM   (NUM),
        .WIDTH (WIDTH)
    ) u_dut (
        .CLK          (clk),
        .nRST         (rst),
        .sort_begin   (sort_begin),
        .FREQUENT_IN  (freq_in),
        .sort_over    (sort_over),
        .FREQUENT_OUT (freq_out)
    );

    task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Insertion-sort reference in the configured order.
    function automatic logic [VW-1:0] ref_sort(input logic [VW-1:0] v);
        logic [WIDTH-1:0] a [NUM];
        logic [WIDTH-1:0] key;
        logic [VW-1:0]    r;
        int               j;
        for (int i = 0; i < NUM; i++) a[i] = v[i*WIDTH +: WIDTH];
        for (int i = 1; i < NUM; i++) begin
            key = a[i];
            j   = i - 1;
`ifdef SORT_DESCEND_EN
            while (j >= 0 && a[j] < key) begin
`else
            while (j >= 0 && a[j] > key) begin
`endif
                a[j+1] = a[j];
                j--;
            end
            a[j+1] = key;
        end
        r = '0;
        for (int i = 0; i < NUM; i++) r[i*WIDTH +: WIDTH] = a[i];
        return r;
    endfunction

    // Call with the block in IDLE, just after an edge; the next rising edge samples the request.
    task automatic run_sort(input string tag, input logic [VW-1:0] exp, input bit scramble);
        sort_begin = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            if (scramble && c == 1) freq_in = ~freq_in;
            if (scramble && c == 3) sort_begin = 1'b0;
            if (scramble && c == 6) sort_begin = 1'b1;
        end
        check_eq({tag, "_busy13"}, {{(VW-1){1'b0}}, sort_over}, '0);
        @(posedge clk);
        #1;
        check_eq({tag, "_over14"}, {{(VW-1){1'b0}}, sort_over}, {{(VW-1){1'b0}}, 1'b1});
        check_eq({tag, "_data"}, freq_out, exp);
    endtask

    task automatic release_done(input string tag, input logic [VW-1:0] exp);
        sort_begin = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, "_drop"}, {{(VW-1){1'b0}}, sort_over}, '0);
        check_eq({tag, "_keep"}, freq_out, exp);
    endtask

    logic [VW-1:0] vec, exp_v, rev_in, rev_asc, ramp, ramp_exp, eq_v;

    initial begin
        vec = 130'h07923a81c38d9868a3241818b885822c0;
        for (int i = 0; i < NUM; i++) begin
            rev_in[i*WIDTH +: WIDTH]   = WIDTH'((12 - i) * 70 + 5);
            rev_asc[i*WIDTH +: WIDTH]  = WIDTH'(i * 70 + 5);
            ramp[i*WIDTH +: WIDTH]     = WIDTH'(i);
            eq_v[i*WIDTH +: WIDTH]     = 10'h155;
`ifdef SORT_DESCEND_EN
            ramp_exp[i*WIDTH +: WIDTH] = WIDTH'(12 - i);
`else
            ramp_exp[i*WIDTH +: WIDTH] = WIDTH'(i);
`endif
        end

        // Reset held with a request pending; release at 100 ns.
        rst        = 1'b1;
        sort_begin = 1'b1;
        freq_in    = vec;
        #50;
        check_eq("rst_over", {{(VW-1){1'b0}}, sort_over}, '0);
        check_eq("rst_data", freq_out, '0);
        #50;
        rst = 1'b0;
        exp_v = ref_sort(vec);
        run_sort("packed", exp_v, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("packed_hold_over", {{(VW-1){1'b0}}, sort_over}, {{(VW-1){1'b0}}, 1'b1});
        check_eq("packed_hold_data", freq_out, exp_v);
        release_done("packed", exp_v);

        // Fresh request after release sorts the current input.
        freq_in = rev_in;
`ifdef SORT_DESCEND_EN
        run_sort("reverse", rev_in, 1'b0);
        release_done("reverse", rev_in);
`else
        run_sort("reverse", rev_asc, 1'b0);
        release_done("reverse", rev_asc);
`endif

        freq_in = eq_v;
        run_sort("equal", eq_v, 1'b0);
        release_done("equal", eq_v);

        freq_in = ramp;
        run_sort("ramp", ramp_exp, 1'b0);
        release_done("ramp", ramp_exp);

        // Input and request toggled mid-sort must not disturb the result.
        vec = 130'h3ff00100a40c8003e7f0155002c9fe0;
        freq_in = vec;
        exp_v = ref_sort(vec);
        run_sort("scramble", exp_v, 1'b1);
        release_done("scramble", exp_v);

        // Abort during pass 6 (cycle after the 8th edge from the request).
        vec = rev_in ^ ramp;
        freq_in = vec;
        sort_begin = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_over", {{(VW-1){1'b0}}, sort_over}, '0);
        check_eq("abort_data", freq_out, '0);
        @(negedge clk);
        rst = 1'b0;
        exp_v = ref_sort(vec);
        run_sort("after_abort", exp_v, 1'b0);
        release_done("after_abort", exp_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort.md
SORT -- requirements
Module: sort

Interface
REQ-001 Parameter NUM, default 13: number of entries to sort.
REQ-002 Parameter WIDTH, default 10: bits per entry; NUM*WIDTH SHALL equal 130.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 nRST  input  1  reset, asynchronous and active-high; the port name is kept as nRST, and a value of 1 resets the block.
REQ-005 sort_begin  input  1  level request to start a sort.
REQ-006 FREQUENT_IN  input  130  packed unsigned entries; entry i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 sort_over  output  1  high while a completed result is held.
REQ-008 FREQUENT_OUT  output  130  registered sorted result, using the same packing as FREQUENT_IN.

Function
REQ-009 The state machine SHALL have four states: IDLE, LOAD, PASS and DONE.
REQ-010 IDLE: if sort_begin=1 at a rising edge, the block SHALL go to LOAD; otherwise it SHALL stay in IDLE.
REQ-011 LOAD: the block SHALL copy FREQUENT_IN into an internal NUM x WIDTH array, clear the pass counter, and go to PASS.
REQ-012 PASS: the block SHALL run one odd-even transposition pass per cycle. Even-numbered passes compare pairs (0,1),(2,3),... Odd-numbered passes compare pairs (1,2),(3,4),... Any pair in the wrong order is swapped.
REQ-013 Default order is ascending, so entry 0 holds the smallest value. Comparison is unsigned. Equal values SHALL NOT be swapped.
REQ-014 After exactly NUM passes the block SHALL go to DONE, register the array into FREQUENT_OUT, and drive sort_over=1.
REQ-015 Latency: sort_over SHALL rise at the rising edge NUM+1 cycles (14 by default) after the edge that sampled sort_begin=1 in IDLE.
REQ-016 DONE: sort_over and FREQUENT_OUT SHALL hold while sort_begin=1. When sort_begin=0, the block SHALL return to IDLE on the next edge and drop sort_over to 0; FREQUENT_OUT SHALL keep its value.
REQ-017 Changes to FREQUENT_IN after LOAD SHALL have no effect on the sort in progress.
REQ-018 Changes to sort_begin during LOAD or PASS SHALL be ignored.
REQ-019 FREQUENT_OUT SHALL change only on entry to DONE or on reset.

Reset
REQ-020 While nRST=1 the block SHALL immediately, without waiting for a clock edge, force: state to IDLE, pass counter to 0, internal array to 0, FREQUENT_OUT to 0, and sort_over to 0.
REQ-021 A reset asserted during PASS SHALL abort the sort and leave no partial result on FREQUENT_OUT.
REQ-022 After nRST falls to 0, sort_begin sampled at 1 on the first rising edge SHALL start a sort.

Configuration
REQ-023 When macro SORT_DESCEND_EN is defined, the sort order SHALL be descending: entry 0 holds the largest value, and equal values are still not swapped. When the macro is undefined, the order SHALL be ascending.

Verification
REQ-024 Reverse input: FREQUENT_IN entries 12..0 loaded with descending values, sort_begin=1 -> after 14 cycles sort_over=1 and FREQUENT_OUT is the fully ascending sequence.
REQ-025 Packed vector: FREQUENT_IN=130'h07923a81c38d9868a3241818b885822c0 held with sort_begin=1 and nRST released at 100 ns -> FREQUENT_OUT is a non-decreasing permutation of the 13 input fields, sort_over=1, and the result holds while sort_begin stays 1.
REQ-026 All entries equal to 10'h155 -> FREQUENT_OUT equals FREQUENT_IN, and sort_over rises at cycle 14.
REQ-027 nRST pulsed to 1 during pass 6 -> sort_over=0 and FREQUENT_OUT=0 immediately; a new request then completes 14 cycles after it is sampled.
REQ-028 In DONE, drop sort_begin to 0 -> sort_over=0 on the next edge and FREQUENT_OUT unchanged; raise sort_begin again -> a fresh sort of the current FREQUENT_IN completes 14 cycles later.
REQ-029 With SORT_DESCEND_EN defined, entries 0..12 loaded with values 0..12 -> FREQUENT_OUT entry 0 = 12 and entry 12 = 0.
